memory_access_sequencer: RTL and testbench
==========================================

MEMORY_ACCESS_SEQUENCER -- requirements
Module: memory_access_sequencer

Interface
REQ-001 Parameter LOAD_LATENCY, default 1, SHALL set the cycles memoryMode is held at LOAD per load (legal range 1-15).
REQ-002 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-low: 0 forces the reset state immediately, regardless of clock.
REQ-004 start  input  1  SHALL be a request to begin one memory access, sampled at the rising clock edge.
REQ-005 isLoad  input  1  SHALL mark the request as a load (lb/lh/lw/lbu/lhu).
REQ-006 isStore  input  1  SHALL mark the request as a store (sb/sh/sw).
REQ-007 funct3In  input  3  SHALL be the instruction funct3, captured on accept.
REQ-008 memoryUnalignedAccess  input  1  SHALL be the memory controller's unaligned-access flag for the current memoryMode.
REQ-009 clearError  input  1  SHALL be a synchronous request to leave ERROR.
REQ-010 memoryMode  output  MemoryMode_t  SHALL drive the memory controller (NOP, LOAD, STORE_PRELOAD, STORE).
REQ-011 funct3  output  3  SHALL drive the controller funct3 with the captured value while busy.
REQ-012 busy  output  1  SHALL be 1 in LOAD, PRELOAD and STORE states (PC/fetch stall).
REQ-013 done  output  1  SHALL pulse 1 for exactly the final cycle of a completed access.
REQ-014 rdWriteEnable  output  1  SHALL be 1 only in the done cycle of a load.
REQ-015 error  output  1  SHALL be 1 while in ERROR.
REQ-016 loadCount, storeCount  output  16 each  SHALL count completed loads/stores.

Function
REQ-017 States SHALL be IDLE, LOAD, PRELOAD, STORE, ERROR; all outputs Moore-decoded from state, counter and captured registers.
REQ-018 memoryMode SHALL be NOP in IDLE and ERROR, LOAD in LOAD, STORE_PRELOAD in PRELOAD, STORE in STORE.
REQ-019 In IDLE with start=1: isLoad only -> LOAD; isStore only -> PRELOAD; both -> ERROR; neither -> stay IDLE; funct3In captured on every transition out of IDLE.
REQ-020 start SHALL be ignored in every state except IDLE; captured funct3 SHALL not change until next accept.
REQ-021 LOAD SHALL last exactly LOAD_LATENCY cycles using a 4-bit cycle counter cleared on entry; done and rdWriteEnable SHALL be 1 in the last LOAD cycle, then -> IDLE.
REQ-022 All stores, including sw, SHALL pass through PRELOAD for exactly 1 cycle, then -> STORE; STORE SHALL last exactly 1 cycle with done=1, then -> IDLE.
REQ-023 memoryUnalignedAccess=1 sampled in LOAD or PRELOAD SHALL -> ERROR at that edge, with no done, no rdWriteEnable, no count increment; STORE SHALL never be entered, so no write occurs.
REQ-024 memoryUnalignedAccess SHALL be ignored in IDLE, STORE and ERROR.
REQ-025 ERROR SHALL persist until clearError=1 at a clock edge (-> IDLE) or reset; start ignored there.
REQ-026 loadCount/storeCount SHALL increment by 1 at the edge ending a done cycle of that kind, wrapping 0xFFFF -> 0x0000.
REQ-027 Latency: load = LOAD_LATENCY cycles busy; store = 2 cycles busy; next start accepted in the cycle after done.

Reset
REQ-028 On reset=0: state IDLE, memoryMode NOP, funct3 3'b000, busy/done/rdWriteEnable/error 0, counters 0, cycle counter 0.
REQ-029 Reset asserted mid-access SHALL abandon it with no done and no STORE cycle; reset release SHALL not by itself start an access.

Verification
REQ-030 LOAD_LATENCY=1, start with isLoad, funct3In=3'b010, aligned -> 1 cycle memoryMode=LOAD, funct3=3'b010, done=rdWriteEnable=1, loadCount=1, then NOP.
REQ-031 LOAD_LATENCY=3, lbu -> LOAD held 3 cycles, done only in cycle 3; start pulsed in cycle 2 ignored.
REQ-032 sb aligned -> STORE_PRELOAD 1 cycle, STORE 1 cycle with done=1, rdWriteEnable=0, storeCount=1.
REQ-033 sw with memoryUnalignedAccess=1 in PRELOAD -> ERROR next cycle, memoryMode never STORE, error=1 until clearError, storeCount=0.
REQ-034 start with isLoad=isStore=1 -> ERROR; storeCount preloaded to 0xFFFF by 65535 stores, one more store -> 0x0000.
REQ-035 reset=0 asynchronously during PRELOAD -> memoryMode NOP before next edge, all outputs at REQ-028 values.

Source files
------------

// File: rtl/memory_access_sequencer_if.sv
// -----------------------------------------------------------------------------
// memory_access_sequencer_if
//
// Request/response bundle between a pipeline front end and the memory access
// sequencer.
//
//   Requester -> sequencer
//     start                 request to begin one memory access
//     isLoad / isStore      access kind (both set is an illegal request)
//     funct3In              instruction funct3, captured when a request is accepted
//     memoryUnalignedAccess controller's unaligned flag for the current memoryMode
//     clearError            leave the ERROR state
//
//   Sequencer -> requester / memory controller
//     memoryMode            2-bit mode: 0 NOP, 1 LOAD, 2 STORE_PRELOAD, 3 STORE
//     funct3                captured funct3 while busy, 0 otherwise
//     busy                  access in flight (stall PC / fetch)
//     done                  final cycle of a completed access
//     rdWriteEnable         register-file write strobe for a completed load
//     error                 sequencer parked in ERROR
//     loadCount/storeCount  completed-access counters (wrap at 16 bits)
//
// memoryMode is carried as a plain 2-bit vector so this file has no
// compile-order dependency; the sequencer owns the MemoryMode_t enum.
// -----------------------------------------------------------------------------
interface memory_access_sequencer_if;

  logic        start;
  logic        isLoad;
  logic        isStore;
  logic [2:0]  funct3In;
  logic        memoryUnalignedAccess;
  logic        clearError;

  logic [1:0]  memoryMode;
  logic [2:0]  funct3;
  logic        busy;
  logic        done;
  logic        rdWriteEnable;
  logic        error;
  logic [15:0] loadCount;
  logic [15:0] storeCount;

  // Requester side: drives requests, observes status.
  modport master (
    output start, isLoad, isStore, funct3In, memoryUnalignedAccess, clearError,
    input  memoryMode, funct3, busy, done, rdWriteEnable, error,
           loadCount, storeCount
  );

  // Sequencer side.
  modport slave (
    input  start, isLoad, isStore, funct3In, memoryUnalignedAccess, clearError,
    output memoryMode, funct3, busy, done, rdWriteEnable, error,
           loadCount, storeCount
  );

endinterface : memory_access_sequencer_if

// File: rtl/memory_access_sequencer.sv
// -----------------------------------------------------------------------------
// memory_access_sequencer
//
// Steps the memory controller through one load or store at a time.
//   load : IDLE -> LOAD (LOAD_LATENCY cycles, done in the last) -> IDLE
//   store: IDLE -> PRELOAD (1 cycle) -> STORE (1 cycle, done) -> IDLE
// An unaligned flag seen in LOAD or PRELOAD aborts to ERROR before any write
// is issued; ERROR holds until clearError. An illegal request (load and store
// both set) goes straight to ERROR.
//
// Parameters
//   LOAD_LATENCY  cycles memoryMode is held at LOAD per load, legal 1..15
//
// Ports
//   clock  rising-edge clock
//   reset  asynchronous, active-low
//   bus    memory_access_sequencer_if.slave (request inputs, status outputs)
// -----------------------------------------------------------------------------
module memory_access_sequencer #(
  parameter int unsigned LOAD_LATENCY = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  memory_access_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    NOP           = 2'd0,
    LOAD          = 2'd1,
    STORE_PRELOAD = 2'd2,
    STORE         = 2'd3
  } MemoryMode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRELOAD,
    S_STORE,
    S_ERROR
  } state_t;

  // Value of the LOAD cycle counter in the final LOAD cycle.
  localparam logic [3:0] LOAD_LAST = 4'(LOAD_LATENCY - 1);

  state_t      state, state_d;
  logic [3:0]  cycle_cnt, cycle_cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [15:0] load_count, store_count;

  logic        load_last;
  logic        load_done;
  logic        store_done;
  MemoryMode_t mode;

  // ---------------------------------------------------------------------------
  // State and captured registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cycle_cnt <= '0;
      funct3_q  <= '0;
    end else begin
      state     <= state_d;
      cycle_cnt <= cycle_cnt_d;
      funct3_q  <= funct3_d;
    end
  end

  // Completed-access counters; 16-bit wrap is the natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (load_done)  load_count  <= load_count + 16'd1;
      if (store_done) store_count <= store_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign load_last = (cycle_cnt == LOAD_LAST);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    funct3_d    = funct3_q;
    cycle_cnt_d = '0;          // counter is zero everywhere except mid-LOAD

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.isLoad && bus.isStore) begin
            state_d = S_ERROR;
          end else if (bus.isLoad) begin
            state_d = S_LOAD;
          end else if (bus.isStore) begin
            state_d = S_PRELOAD;
          end
          // funct3 is latched on any exit from IDLE, including the illegal one.
          if (bus.isLoad || bus.isStore) begin
            funct3_d = bus.funct3In;
          end
        end
      end

      S_LOAD: begin
        if (bus.memoryUnalignedAccess) begin
          state_d = S_ERROR;
        end else if (load_last) begin
          state_d = S_IDLE;
        end else begin
          cycle_cnt_d = cycle_cnt + 4'd1;
        end
      end

      // Every store, word or not, spends one cycle here so the controller can
      // read-modify-write; an unaligned flag aborts before STORE is reached.
      S_PRELOAD: begin
        state_d = bus.memoryUnalignedAccess ? S_ERROR : S_STORE;
      end

      S_STORE: begin
        state_d = S_IDLE;
      end

      S_ERROR: begin
        if (bus.clearError) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    mode = NOP;
    unique case (state)
      S_LOAD:    mode = LOAD;
      S_PRELOAD: mode = STORE_PRELOAD;
      S_STORE:   mode = STORE;
      default:   mode = NOP;
    endcase
  end

  // A load faulting in its final cycle must not write the register file, so
  // the completion strobe is suppressed by the controller's unaligned flag.
  assign load_done  = (state == S_LOAD) && load_last && !bus.memoryUnalignedAccess;
  assign store_done = (state == S_STORE);

  assign bus.memoryMode    = mode;
  assign bus.busy          = (state == S_LOAD) || (state == S_PRELOAD) ||
                             (state == S_STORE);
  assign bus.funct3        = bus.busy ? funct3_q : 3'b000;
  assign bus.done          = load_done || store_done;
  assign bus.rdWriteEnable = load_done;
  assign bus.error         = (state == S_ERROR);
  assign bus.loadCount     = load_count;
  assign bus.storeCount    = store_count;

endmodule : memory_access_sequencer

// File: tb/tb_memory_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_memory_access_sequencer
//
// Two sequencers: u_dut1 with LOAD_LATENCY=1 runs a table of single accesses
// and the wrap/reset corner cases; u_dut3 with LOAD_LATENCY=3 runs the
// multi-cycle load sequences. Completed accesses on u_dut1 are pushed to a
// scoreboard when requested and checked when done is seen.
// -----------------------------------------------------------------------------
module tb_memory_access_sequencer;

  localparam logic [1:0] MM_NOP     = 2'd0;
  localparam logic [1:0] MM_LOAD    = 2'd1;
  localparam logic [1:0] MM_PRELOAD = 2'd2;
  localparam logic [1:0] MM_STORE   = 2'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  memory_access_sequencer_if bus1();
  memory_access_sequencer_if bus3();

  memory_access_sequencer #(.LOAD_LATENCY(1)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  memory_access_sequencer #(.LOAD_LATENCY(3)) u_dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard for u_dut1 completions
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         is_load;
    logic [2:0] f3;
  } sb_t;

  sb_t sb_q[$];
  logic [15:0] exp_load_cnt  = 16'd0;
  logic [15:0] exp_store_cnt = 16'd0;

  always @(negedge clock) begin
    sb_t e;
    if (reset && bus1.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_done: done=1 with no pending access (t=%0t)", $time);
      end else begin
        e = sb_q.pop_front();
        check("sb_rdWriteEnable", bus1.rdWriteEnable, e.is_load);
        check("sb_funct3", bus1.funct3, e.f3);
        check("sb_mode", bus1.memoryMode, e.is_load ? MM_LOAD : MM_STORE);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vector table for u_dut1: request in cycle 0, observe cycles 1 and 2.
  // unal[0] is driven during cycle 1, unal[1] during cycle 2.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         ld;
    bit         st;
    logic [2:0] f3;
    bit   [1:0] unal;
    logic [1:0] m1;
    logic [1:0] m2;
    bit         d1;
    bit         d2;
    bit         e1;
    bit         e2;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs[NVEC];

  task automatic idle_inputs();
    bus1.start = 1'b0; bus1.isLoad = 1'b0; bus1.isStore = 1'b0;
    bus1.funct3In = 3'b000; bus1.memoryUnalignedAccess = 1'b0; bus1.clearError = 1'b0;
    bus3.start = 1'b0; bus3.isLoad = 1'b0; bus3.isStore = 1'b0;
    bus3.funct3In = 3'b000; bus3.memoryUnalignedAccess = 1'b0; bus3.clearError = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ld st f3      unal   m1          m2        d1 d2 e1 e2
    vecs[0] = '{1, 0, 3'b010, 2'b00, MM_LOAD,    MM_NOP,   1, 0, 0, 0}; // lw
    vecs[1] = '{1, 0, 3'b100, 2'b00, MM_LOAD,    MM_NOP,   1, 0, 0, 0}; // lbu
    vecs[2] = '{0, 1, 3'b000, 2'b00, MM_PRELOAD, MM_STORE, 0, 1, 0, 0}; // sb
    vecs[3] = '{0, 1, 3'b010, 2'b01, MM_PRELOAD, MM_NOP,   0, 0, 0, 1}; // sw unaligned
    vecs[4] = '{1, 1, 3'b010, 2'b01, MM_NOP,     MM_NOP,   0, 0, 1, 1}; // illegal
    vecs[5] = '{0, 0, 3'b111, 2'b00, MM_NOP,     MM_NOP,   0, 0, 0, 0}; // neither
    vecs[6] = '{0, 1, 3'b001, 2'b10, MM_PRELOAD, MM_STORE, 0, 1, 0, 0}; // sh, flag in STORE
    vecs[7] = '{1, 0, 3'b101, 2'b10, MM_LOAD,    MM_NOP,   1, 0, 0, 0}; // lhu, flag in IDLE
    vecs[8] = '{0, 1, 3'b000, 2'b00, MM_PRELOAD, MM_STORE, 0, 1, 0, 0}; // sb

    idle_inputs();

    // ---- Reset state (asynchronous: checked before any clock edge) ----
    #1 reset = 1'b0;
    #2;
    check("rst_mode",   bus1.memoryMode, MM_NOP);
    check("rst_funct3", bus1.funct3, 3'b000);
    check("rst_flags",  {bus1.busy, bus1.done, bus1.rdWriteEnable, bus1.error}, 4'b0000);
    check("rst_counts", {bus1.loadCount, bus1.storeCount}, 32'd0);
    check("rst_mode_d3", bus3.memoryMode, MM_NOP);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    check("post_rst_idle", {bus1.memoryMode, bus1.busy, bus3.memoryMode, bus3.busy},
          {MM_NOP, 1'b0, MM_NOP, 1'b0});

    // ---- Table-driven single accesses on u_dut1 ----
    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("v%0d_idle_mode", i), bus1.memoryMode, MM_NOP);
      bus1.start    = 1'b1;
      bus1.isLoad   = vecs[i].ld;
      bus1.isStore  = vecs[i].st;
      bus1.funct3In = vecs[i].f3;
      if ((vecs[i].ld ^ vecs[i].st) && !vecs[i].e2) begin
        sb_q.push_back('{is_load: vecs[i].ld, f3: vecs[i].f3});
        if (vecs[i].ld) exp_load_cnt++;
        else            exp_store_cnt++;
      end
      step();
      // cycle 1: funct3In changes to prove the captured value holds
      bus1.start = 1'b0; bus1.isLoad = 1'b0; bus1.isStore = 1'b0;
      bus1.funct3In = 3'b011;
      bus1.memoryUnalignedAccess = vecs[i].unal[0];
      check($sformatf("v%0d_c1_mode", i), bus1.memoryMode, vecs[i].m1);
      check($sformatf("v%0d_c1_flags", i),
            {bus1.busy, bus1.done, bus1.rdWriteEnable, bus1.error},
            {vecs[i].m1 != MM_NOP, vecs[i].d1, vecs[i].d1 & vecs[i].ld, vecs[i].e1});
      if (vecs[i].m1 != MM_NOP)
        check($sformatf("v%0d_c1_funct3", i), bus1.funct3, vecs[i].f3);
      step();
      bus1.memoryUnalignedAccess = vecs[i].unal[1];
      check($sformatf("v%0d_c2_mode", i), bus1.memoryMode, vecs[i].m2);
      check($sformatf("v%0d_c2_flags", i),
            {bus1.busy, bus1.done, bus1.rdWriteEnable, bus1.error},
            {vecs[i].m2 != MM_NOP, vecs[i].d2, 1'b0, vecs[i].e2});
      if (vecs[i].m2 != MM_NOP)
        check($sformatf("v%0d_c2_funct3", i), bus1.funct3, vecs[i].f3);
      step();
      bus1.memoryUnalignedAccess = 1'b0;
      if (vecs[i].e2) begin
        // start is ignored in ERROR
        bus1.start = 1'b1; bus1.isLoad = 1'b1;
        step();
        check($sformatf("v%0d_err_hold", i), {bus1.error, bus1.memoryMode}, {1'b1, MM_NOP});
        bus1.start = 1'b0; bus1.isLoad = 1'b0; bus1.clearError = 1'b1;
        step();
        bus1.clearError = 1'b0;
        check($sformatf("v%0d_err_clear", i), {bus1.error, bus1.memoryMode}, {1'b0, MM_NOP});
      end
    end
    check("tbl_load_count",  bus1.loadCount,  exp_load_cnt);
    check("tbl_store_count", bus1.storeCount, exp_store_cnt);
    check("tbl_sb_drained",  sb_q.size(), 0);

    // ---- u_dut3: lbu held 3 cycles, start pulse in cycle 2 ignored ----
    bus3.start = 1'b1; bus3.isLoad = 1'b1; bus3.funct3In = 3'b100;
    step();
    bus3.start = 1'b0; bus3.isLoad = 1'b0; bus3.funct3In = 3'b000;
    check("l3_c1", {bus3.memoryMode, bus3.done, bus3.rdWriteEnable, bus3.funct3},
          {MM_LOAD, 1'b0, 1'b0, 3'b100});
    step();
    check("l3_c2", {bus3.memoryMode, bus3.done, bus3.funct3}, {MM_LOAD, 1'b0, 3'b100});
    bus3.start = 1'b1; bus3.isStore = 1'b1; bus3.funct3In = 3'b010;
    step();
    bus3.start = 1'b0; bus3.isStore = 1'b0; bus3.funct3In = 3'b000;
    check("l3_c3", {bus3.memoryMode, bus3.done, bus3.rdWriteEnable, bus3.funct3},
          {MM_LOAD, 1'b1, 1'b1, 3'b100});
    check("l3_c3_count", bus3.loadCount, 16'd0);
    step();
    check("l3_c4", {bus3.memoryMode, bus3.busy, bus3.done}, {MM_NOP, 1'b0, 1'b0});
    check("l3_c4_count", bus3.loadCount, 16'd1);
    step();
    check("l3_c5_ignored", {bus3.memoryMode, bus3.storeCount}, {MM_NOP, 16'd0});

    // ---- u_dut3: unaligned in first LOAD cycle aborts without done ----
    bus3.start = 1'b1; bus3.isLoad = 1'b1; bus3.funct3In = 3'b001;
    step();
    bus3.start = 1'b0; bus3.isLoad = 1'b0;
    bus3.memoryUnalignedAccess = 1'b1;
    check("lu_c1", {bus3.memoryMode, bus3.done}, {MM_LOAD, 1'b0});
    step();
    bus3.memoryUnalignedAccess = 1'b0;
    check("lu_err", {bus3.error, bus3.memoryMode, bus3.done, bus3.rdWriteEnable},
          {1'b1, MM_NOP, 1'b0, 1'b0});
    step();
    check("lu_count", bus3.loadCount, 16'd1);
    bus3.clearError = 1'b1;
    step();
    bus3.clearError = 1'b0;
    check("lu_cleared", {bus3.error, bus3.busy}, 2'b00);

    // ---- u_dut1: storeCount wrap 0xFFFF -> 0x0000 ----
    // Preloading by 65535 real stores would take ~200k cycles, so the counter
    // register is set directly while the sequencer is idle.
    force u_dut1.store_count = 16'hFFFF;
    #1 release u_dut1.store_count;
    exp_store_cnt = 16'hFFFF;
    check("wrap_pre", bus1.storeCount, exp_store_cnt);
    bus1.start = 1'b1; bus1.isStore = 1'b1; bus1.funct3In = 3'b000;
    sb_q.push_back('{is_load: 1'b0, f3: 3'b000});
    exp_store_cnt++;
    step();
    bus1.start = 1'b0; bus1.isStore = 1'b0;
    step();
    step();
    check("wrap_post", bus1.storeCount, exp_store_cnt);
    check("wrap_mode", bus1.memoryMode, MM_NOP);

    // ---- u_dut1: asynchronous reset during PRELOAD ----
    bus1.start = 1'b1; bus1.isStore = 1'b1; bus1.funct3In = 3'b010;
    step();
    bus1.start = 1'b0; bus1.isStore = 1'b0;
    check("ar_preload", bus1.memoryMode, MM_PRELOAD);
    #1 reset = 1'b0;
    #1;
    check("ar_mode",   bus1.memoryMode, MM_NOP);
    check("ar_flags",  {bus1.busy, bus1.done, bus1.rdWriteEnable, bus1.error, bus1.funct3},
          7'b0);
    check("ar_counts", {bus1.loadCount, bus1.storeCount}, 32'd0);
    step();
    reset = 1'b1;
    step();
    check("ar_after1", {bus1.memoryMode, bus1.busy}, {MM_NOP, 1'b0});
    step();
    check("ar_after2", {bus1.memoryMode, bus1.storeCount}, {MM_NOP, 16'd0});
    check("end_sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_memory_access_sequencer
